// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port: A wins, B is forced after MAX_WAIT lost cycles.
// Optional saturating statistics counters built only when WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_wsel,
  input  logic [31:0]       a_wdat,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_wsel,
  input  logic [31:0]       b_wdat,
  output logic              rf_WEN,
  output logic [4:0]        rf_wsel,
  output logic [31:0]       rf_wdat,
  output logic [STAT_W-1:0] conflict_cnt,
  output logic [STAT_W-1:0] force_cnt
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {NORMAL, FORCE_B} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          a_xfer, b_xfer;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Readies decode from state and the other port's valid only, never their own valid.
  always_comb begin
    a_ready   = 1'b1;
    b_ready   = !a_valid;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      NORMAL: begin
        if (b_valid && !b_ready) begin
          wait_nxt = wait_cnt + 1'b1;
          if (wait_cnt == CW'(MAX_WAIT - 1)) state_nxt = FORCE_B;
        end else begin
          wait_nxt = '0;
        end
      end
      FORCE_B: begin
        a_ready   = 1'b0;
        b_ready   = 1'b1;
        state_nxt = NORMAL;
        wait_nxt  = '0;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  // Register 0 writes still complete the handshake but never assert WEN.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rf_WEN  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
    end else if (a_xfer) begin
      rf_WEN  <= (a_wsel != 5'd0);
      rf_wsel <= a_wsel;
      rf_wdat <= a_wdat;
    end else if (b_xfer) begin
      rf_WEN  <= (b_wsel != 5'd0);
      rf_wsel <= b_wsel;
      rf_wdat <= b_wdat;
    end else begin
      rf_WEN  <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic force_go;
  assign force_go = (state == NORMAL) && (state_nxt == FORCE_B);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (a_valid && b_valid && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
      if (force_go && (force_cnt != '1))              force_cnt    <= force_cnt + 1'b1;
    end
  end
`else
  assign conflict_cnt = '0;
  assign force_cnt    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table vectors plus hand sequences, expected writes scoreboarded per cycle.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int STAT_W   = 4;
`ifdef WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              nRST;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [4:0]        a_wsel, b_wsel;
  logic [31:0]       a_wdat, b_wdat;
  logic              rf_WEN;
  logic [4:0]        rf_wsel;
  logic [31:0]       rf_wdat;
  logic [STAT_W-1:0] conflict_cnt, force_cnt;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .STAT_W(STAT_W)) dut (
    .clk(clk), .nRST(nRST),
    .a_valid(a_valid), .a_ready(a_ready), .a_wsel(a_wsel), .a_wdat(a_wdat),
    .b_valid(b_valid), .b_ready(b_ready), .b_wsel(b_wsel), .b_wdat(b_wdat),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .conflict_cnt(conflict_cnt), .force_cnt(force_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] aw; logic [31:0] ad;
    logic bv; logic [4:0] bw; logic [31:0] bd;
    logic ar; logic br;
  } vec_t;

  typedef struct {
    logic wen; logic chk; logic [4:0] wsel; logic [31:0] wdat;
  } exp_t;

  exp_t q[$];
  vec_t vecs[10];
  int tests = 0;
  int fails = 0;
  int m_conf = 0;
  int m_force = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive, check readies, push expected write, clock, compare write and stats.
  task automatic cyc(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                     input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                     input logic ear, input logic ebr, input string name);
    exp_t e;
    exp_t got;
    a_valid = av; a_wsel = aw; a_wdat = ad;
    b_valid = bv; b_wsel = bw; b_wdat = bd;
    #2;
    check({name, " a_ready"}, {31'd0, a_ready}, {31'd0, ear});
    check({name, " b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
    if (av && bv && m_conf != 15) m_conf++;
    if (!ear && ebr && m_force != 15) m_force++;
    e = '{wen: 1'b0, chk: 1'b0, wsel: 5'd0, wdat: 32'd0};
    if (av && ear)      e = '{wen: (aw != 0), chk: (aw != 0), wsel: aw, wdat: ad};
    else if (bv && ebr) e = '{wen: (bw != 0), chk: (bw != 0), wsel: bw, wdat: bd};
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s scoreboard: got empty queue expected entry", name);
    end else begin
      got = q.pop_front();
      check({name, " rf_WEN"}, {31'd0, rf_WEN}, {31'd0, got.wen});
      if (got.chk) begin
        check({name, " rf_wsel"}, {27'd0, rf_wsel}, {27'd0, got.wsel});
        check({name, " rf_wdat"}, rf_wdat, got.wdat);
      end
    end
    check({name, " conflict_cnt"}, {28'd0, conflict_cnt}, STATS ? 32'(m_conf) : 32'd0);
    check({name, " force_cnt"}, {28'd0, force_cnt}, STATS ? 32'(m_force) : 32'd0);
  endtask

  initial begin
    vecs[0] = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 0};
    vecs[1] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  1, 1};
    vecs[2] = '{0, 5'd0,  32'h0,        1, 5'd3, 32'h33, 1, 1};
    vecs[3] = '{1, 5'd31, 32'hA5A5A5A5, 1, 5'd7, 32'h77, 1, 0};
    vecs[4] = '{1, 5'd2,  32'h2,        1, 5'd7, 32'h77, 1, 0};
    vecs[5] = '{0, 5'd0,  32'h0,        1, 5'd7, 32'h77, 1, 1};
    vecs[6] = '{1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 32'h0,  1, 0};
    vecs[7] = '{1, 5'd17, 32'h11111111, 1, 5'd8, 32'h88, 1, 0};
    vecs[8] = '{0, 5'd0,  32'h0,        1, 5'd8, 32'h88, 1, 1};
    vecs[9] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  1, 1};

    nRST = 1'b0;
    a_valid = 0; a_wsel = 0; a_wdat = 0; b_valid = 0; b_wsel = 0; b_wdat = 0;
    #3;
    check("reset rf_WEN", {31'd0, rf_WEN}, 32'd0);
    check("reset rf_wsel", {27'd0, rf_wsel}, 32'd0);
    check("reset rf_wdat", rf_wdat, 32'd0);
    check("reset conflict_cnt", {28'd0, conflict_cnt}, 32'd0);
    check("reset a_ready", {31'd0, a_ready}, 32'd1);
    a_valid = 1; b_valid = 1;
    #1;
    check("reset b_ready busy", {31'd0, b_ready}, 32'd0);
    a_valid = 0; b_valid = 0;
    #1;
    check("reset b_ready idle", {31'd0, b_ready}, 32'd1);
    @(posedge clk);
    #1 nRST = 1'b1;

    for (int i = 0; i < 10; i++)
      cyc(vecs[i].av, vecs[i].aw, vecs[i].ad, vecs[i].bv, vecs[i].bw, vecs[i].bd,
          vecs[i].ar, vecs[i].br, $sformatf("vec%0d", i));

    // Idle A lets B through at once; the subsequent starvation needs the full 4 lost cycles.
    cyc(0, 5'd0, 32'h0, 1, 5'd4, 32'h44, 1, 1, "idleA");
    for (int i = 0; i < 4; i++)
      cyc(1, 5'(10 + i), 32'(i), 1, 5'd9, 32'h1234, 1, 0, $sformatf("starve%0d", i));
    cyc(1, 5'd14, 32'h4, 1, 5'd9, 32'h1234, 0, 1, "forceB");
    check("force_cnt after starve", {28'd0, force_cnt}, STATS ? 32'd1 : 32'd0);
    cyc(1, 5'd14, 32'h4, 0, 5'd0, 32'h0, 1, 0, "afterForce");

    // 20 conflict cycles saturate a 4-bit conflict counter.
    for (int i = 0; i < 20; i++)
      cyc(1, 5'(1 + i), 32'(100 + i), 1, 5'(20 + i / 5), 32'(i / 5),
          (i % 5 != 4), (i % 5 == 4), $sformatf("sat%0d", i));
    check("conflict saturated", {28'd0, conflict_cnt}, STATS ? 32'hF : 32'd0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, "idle");

    // Reset taken while the FSM sits in FORCE_B with a write in flight.
    for (int i = 0; i < 4; i++)
      cyc(1, 5'd12, 32'hCAFE, 1, 5'd6, 32'h66, 1, 0, $sformatf("pre%0d", i));
    #1;
    check("mid FORCE_B a_ready", {31'd0, a_ready}, 32'd0);
    nRST = 1'b0;
    #1;
    check("async rf_WEN", {31'd0, rf_WEN}, 32'd0);
    check("async rf_wsel", {27'd0, rf_wsel}, 32'd0);
    check("async rf_wdat", rf_wdat, 32'd0);
    check("async a_ready", {31'd0, a_ready}, 32'd1);
    check("async b_ready", {31'd0, b_ready}, 32'd0);
    check("async force_cnt", {28'd0, force_cnt}, 32'd0);
    q.delete();
    m_conf = 0; m_force = 0;
    @(posedge clk);
    #1;
    check("in reset rf_WEN", {31'd0, rf_WEN}, 32'd0);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(1, 5'd12, 32'hCAFE, 1, 5'd6, 32'h66, 1, 0, $sformatf("post%0d", i));
    cyc(1, 5'd12, 32'hCAFE, 1, 5'd6, 32'h66, 0, 1, "postForce");
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
